// File: rtl/arcfour_pkg.sv
// Shared definitions for the arcfour key-search blocks: message reader state
// encoding and the width/limit of the failed-key counter.
package arcfour_pkg;

  localparam int KEYS_TRIED_W = 24;
  localparam logic [KEYS_TRIED_W-1:0] KEYS_TRIED_MAX = {KEYS_TRIED_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } reader_state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse in the cycle a level input first
// reads high. History register clears on the asynchronous active-low reset.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // Remember the previous sample of the level input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/message_reader.sv
// Message reader: once the key search terminates successfully, latches the
// winning key and streams the decrypted message out of RAM-A one byte at a
// time; on an unsuccessful search it reports completion straight away.
// Also counts the keys that failed to decrypt.
//
// Output handshake: char_data is offered while char_valid is high and is held
// stable until a cycle in which char_valid && char_ready are both high at the
// rising clock edge, which is the transfer. char_valid is a register output and
// never depends combinationally on char_ready.
module message_reader
  import arcfour_pkg::*;
#(
  parameter int RAM_WIDTH          = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int KEY_LENGTH         = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             arcfour_finished,
  input  logic                             arcfour_terminated,
  input  logic                             success,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic [MESSAGE_LOG_LENGTH-1:0]    bAddr,
  input  logic [RAM_WIDTH-1:0]             bOut,
  output logic [RAM_WIDTH-1:0]             char_data,
  output logic                             char_valid,
  input  logic                             char_ready,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  found_key,
  output logic                             key_found,
  output logic                             done,
  output logic [KEYS_TRIED_W-1:0]          keys_tried,
  output reader_state_t                    state
);

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_ADDR =
    MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  logic start_pulse;
  logic term_pulse;
  logic fin_q;
  logic fin_pulse;

  edge_detector u_start_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .pulse (start_pulse)
  );

  edge_detector u_term_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (arcfour_terminated),
    .pulse (term_pulse)
  );

  assign fin_pulse = arcfour_finished & ~fin_q;

  // Failed-key counter: counts finished edges, saturates, cleared by a new search.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_q      <= 1'b0;
      keys_tried <= '0;
    end else begin
      fin_q <= arcfour_finished;
      if (start_pulse)
        keys_tried <= '0;
      else if (fin_pulse && keys_tried != KEYS_TRIED_MAX)
        keys_tried <= keys_tried + KEYS_TRIED_W'(1);
    end
  end

  // Reader FSM: fetch each byte, wait one cycle for RAM data, offer it downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bAddr      <= '0;
      char_data  <= '0;
      char_valid <= 1'b0;
      found_key  <= '0;
      key_found  <= 1'b0;
      done       <= 1'b0;
    end else if (start_pulse) begin
      // A new search abandons whatever is in flight.
      state      <= ST_IDLE;
      bAddr      <= '0;
      char_valid <= 1'b0;
      key_found  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (term_pulse) begin
            if (success) begin
              found_key <= key;
              key_found <= 1'b1;
              bAddr     <= '0;
              state     <= ST_FETCH;
            end else begin
              key_found <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          char_data  <= bOut;
          char_valid <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            if (bAddr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              bAddr <= bAddr + MESSAGE_LOG_LENGTH'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/message_reader.md
MESSAGE_READER -- requirements
Module: message_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data width of RAM-A words and key bytes.
REQ-002 SHALL have parameter MESSAGE_LENGTH, default 32, number of plaintext bytes in RAM-A.
REQ-003 SHALL have parameter MESSAGE_LOG_LENGTH, default 5, RAM-A address width.
REQ-004 SHALL have parameter KEY_LENGTH, default 3, key bytes.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  level from search launcher; rising edge marks a new search.
REQ-008 SHALL have port arcfour_finished  input  1  high for one key that did not decrypt.
REQ-009 SHALL have port arcfour_terminated  input  1  search ended.
REQ-010 SHALL have port success  input  1  plaintext valid when terminated.
REQ-011 SHALL have port key  input  KEY_LENGTH*RAM_WIDTH  key under test.
REQ-012 SHALL have port bAddr  output  MESSAGE_LOG_LENGTH  RAM-A read-port address.
REQ-013 SHALL have port bOut  input  RAM_WIDTH  RAM-A read data, valid 1 cycle after bAddr.
REQ-014 SHALL have port char_data  output  RAM_WIDTH  plaintext byte.
REQ-015 SHALL have port char_valid  output  1  char_data valid.
REQ-016 SHALL have port char_ready  input  1  consumer accepts.
REQ-017 SHALL have port found_key  output  KEY_LENGTH*RAM_WIDTH  latched winning key.
REQ-018 SHALL have port key_found  output  1  search ended with success.
REQ-019 SHALL have port done  output  1  report complete.
REQ-020 SHALL have port keys_tried  output  24  failed-key count.

Function
REQ-021 SHALL rising-edge detect start and arcfour_terminated internally (one-cycle pulses).
REQ-022 SHALL implement states IDLE, FETCH, WAIT, SEND, DONE.
REQ-023 IDLE: on terminated pulse with success=1 -> latch key into found_key, set key_found, bAddr=0, go FETCH; with success=0 -> clear key_found, go DONE.
REQ-024 FETCH: present bAddr, go WAIT (1 cycle).
REQ-025 WAIT: register bOut into char_data, go SEND.
REQ-026 SEND: char_valid=1; char_data SHALL stay stable until char_valid && char_ready.
REQ-027 On transfer with bAddr < MESSAGE_LENGTH-1: increment bAddr, go FETCH; at bAddr == MESSAGE_LENGTH-1: go DONE; bAddr SHALL NOT wrap.
REQ-028 char_valid SHALL not depend combinationally on char_ready.
REQ-029 DONE: done=1, hold until start pulse.
REQ-030 start pulse in any state SHALL return to IDLE next cycle, clearing done, key_found, char_valid, bAddr, keys_tried; an in-flight byte is dropped.
REQ-031 keys_tried SHALL increment on each arcfour_finished rising edge, saturate at 24'hFFFFFF; start pulse coinciding with increment SHALL clear (clear wins).
REQ-032 terminated pulse outside IDLE SHALL be ignored.
REQ-033 Per byte: 3 cycles minimum (FETCH, WAIT, SEND with ready high).

Reset
REQ-034 reset low SHALL force IDLE, all outputs 0 (bAddr, char_data, char_valid, found_key, key_found, done, keys_tried), edge-detector history 0, asynchronously.

Structure
REQ-035 SHALL place the state typedef and the keys_tried width constant in the shared arcfour package.
REQ-036 SHALL instantiate the existing edge_detector for start and arcfour_terminated; no other sub-module.

Verification
REQ-037 success=1, key=24'h0A1B2C, RAM-A = 0x41+i, ready always 1 -> 32 bytes 0x41..0x60 in order, bAddr 0..31, found_key=24'h0A1B2C, done after last.
REQ-038 ready toggled 1-of-3 cycles -> identical byte stream, char_data stable while valid && !ready.
REQ-039 success=0 at terminate after 5 finished pulses -> no char_valid, key_found=0, done=1, keys_tried=5.
REQ-040 start pulse during byte 10 -> IDLE next cycle, char_valid=0, keys_tried=0, done=0.
REQ-041 reset low mid-SEND -> all outputs 0 immediately, before next clk edge.
REQ-042 keys_tried preloaded near 24'hFFFFFF, 3 finished pulses -> holds 24'hFFFFFF.
